stream_gearbox_unpacker: RTL and testbench

//  Generalised width converter between a packed read-side source (1-cycle read latency) and a write-side sink.

---
 rtl/stream_gearbox_unpacker_if.sv | 36 +++
 rtl/stream_gearbox_unpacker.sv | 94 +++++++++
 tb/tb_stream_gearbox_unpacker.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stream_gearbox_unpacker_if.sv
// Bundles the source read port, sink write port, flush control and debug taps
// of stream_gearbox_unpacker.
interface stream_gearbox_unpacker_if #(
  parameter int IN_WIDTH  = 128,
  parameter int OUT_WIDTH = 64
);
  localparam int LEVEL_W = $clog2(IN_WIDTH + OUT_WIDTH + 1);

  // Handshakes: a source word is popped in any cycle where m_packed_read_req is
  // high (it is only raised while m_packed_read_ready is high) and its data must
  // be on m_packed_read_data in the following cycle; an output word transfers in
  // any cycle where m_unpacked_write_req and m_unpacked_write_ready are both high.
  logic                 m_packed_read_ready;
  logic                 m_packed_read_req;
  logic [IN_WIDTH-1:0]  m_packed_read_data;
  logic                 m_unpacked_write_ready;
  logic                 m_unpacked_write_req;
  logic [OUT_WIDTH-1:0] m_unpacked_write_data;
  logic                 flush;
  logic                 flush_done;
  logic [LEVEL_W-1:0]   dbg_level;
  logic                 dbg_rd_valid;
  logic                 dbg_flush_pend;

  modport master (
    input  m_packed_read_ready, m_packed_read_data, m_unpacked_write_ready, flush,
    output m_packed_read_req, m_unpacked_write_req, m_unpacked_write_data, flush_done,
    output dbg_level, dbg_rd_valid, dbg_flush_pend
  );

  modport slave (
    output m_packed_read_ready, m_packed_read_data, m_unpacked_write_ready, flush,
    input  m_packed_read_req, m_unpacked_write_req, m_unpacked_write_data, flush_done,
    input  dbg_level, dbg_rd_valid, dbg_flush_pend
  );
endinterface

// File: rtl/stream_gearbox_unpacker.sv
// Arbitrary-ratio width converter: packed source words are appended LSB-first to a
// residual bit buffer and drained as OUT_WIDTH words, with a zero-padded flush tail.
module stream_gearbox_unpacker #(
  parameter int IN_WIDTH  = 128,
  parameter int OUT_WIDTH = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  stream_gearbox_unpacker_if.master bus
);
  localparam int BUF_W   = IN_WIDTH + OUT_WIDTH;
  localparam int LEVEL_W = $clog2(BUF_W + 1);
  localparam int SUM_W   = LEVEL_W + 2;

  typedef enum logic {FL_IDLE, FL_PEND} fl_state_e;

  logic [BUF_W-1:0]   data_buf_q, data_buf_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic               rd_valid_q, rd_valid_d;
  fl_state_e          fl_state_q, fl_state_d;

  logic               flush_pend;
  logic               full_word;
  logic               tail;
  logic               write_req;
  logic               pop;
  logic               read_req;
  logic               flush_done;
  logic [LEVEL_W-1:0] take;
  logic [LEVEL_W-1:0] lvl_ap;
  logic [SUM_W-1:0]   need;
  logic [BUF_W-1:0]   shifted;

  always_comb begin
    flush_pend = (fl_state_q == FL_PEND);
    full_word  = (level_q >= LEVEL_W'(OUT_WIDTH));
    tail       = flush_pend && !rd_valid_q && (level_q != '0) && !full_word;
    write_req  = full_word || tail;
    pop        = write_req && bus.m_unpacked_write_ready;

    take = '0;
    if (pop) take = full_word ? LEVEL_W'(OUT_WIDTH) : level_q;
    lvl_ap = level_q - take;

    // Room is reserved for the word already in flight plus the one requested now.
    need     = SUM_W'(lvl_ap) + SUM_W'(IN_WIDTH) + (rd_valid_q ? SUM_W'(IN_WIDTH) : '0);
    read_req = !reset && bus.m_packed_read_ready && !flush_pend && (need <= SUM_W'(BUF_W));

    // Bits above level are always zero, so a tail pop leaves the buffer empty.
    shifted    = pop ? (data_buf_q >> OUT_WIDTH) : data_buf_q;
    data_buf_d = shifted;
    level_d    = lvl_ap;
    if (rd_valid_q) begin
      data_buf_d = shifted | (BUF_W'(bus.m_packed_read_data) << lvl_ap);
      level_d    = lvl_ap + LEVEL_W'(IN_WIDTH);
    end
    rd_valid_d = read_req;

    fl_state_d = fl_state_q;
    flush_done = 1'b0;
    case (fl_state_q)
      FL_IDLE: if (bus.flush) fl_state_d = FL_PEND;
      FL_PEND: begin
        if (!rd_valid_q && (level_q == '0)) begin
          flush_done = 1'b1;
          fl_state_d = FL_IDLE;
        end
      end
      default: fl_state_d = FL_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_buf_q <= '0;
      level_q    <= '0;
      rd_valid_q <= 1'b0;
      fl_state_q <= FL_IDLE;
    end else begin
      data_buf_q <= data_buf_d;
      level_q    <= level_d;
      rd_valid_q <= rd_valid_d;
      fl_state_q <= fl_state_d;
    end
  end

  assign bus.m_packed_read_req     = read_req;
  assign bus.m_unpacked_write_req  = write_req;
  assign bus.m_unpacked_write_data = data_buf_q[OUT_WIDTH-1:0];
  assign bus.flush_done            = flush_done;
  assign bus.dbg_level             = level_q;
  assign bus.dbg_rd_valid          = rd_valid_q;
  assign bus.dbg_flush_pend        = flush_pend;
endmodule

// File: tb/tb_stream_gearbox_unpacker.sv
// Bench for stream_gearbox_unpacker: a 128->64 and a 64->48 instance driven by
// queue-backed sources/sinks and checked against a bit-stream reference model.
module tb_stream_gearbox_unpacker;
  localparam int AI = 128;
  localparam int AO = 64;
  localparam int BI = 64;
  localparam int BO = 48;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  stream_gearbox_unpacker_if #(.IN_WIDTH(AI), .OUT_WIDTH(AO)) ifa ();
  stream_gearbox_unpacker_if #(.IN_WIDTH(BI), .OUT_WIDTH(BO)) ifb ();

  stream_gearbox_unpacker #(.IN_WIDTH(AI), .OUT_WIDTH(AO)) u_dut_a (.clk(clk), .reset(reset), .bus(ifa));
  stream_gearbox_unpacker #(.IN_WIDTH(BI), .OUT_WIDTH(BO)) u_dut_b (.clk(clk), .reset(reset), .bus(ifb));

  // ---------------- scoreboard state ----------------
  int vectors = 0;
  int miscompares = 0;

  logic [AI-1:0] srca_q[$];
  logic [AO-1:0] expa_q[$];
  logic [AO-1:0] gota_q[$];
  int            gota_cyc[$];
  int            reqa_cyc[$];
  bit            bitsa_q[$];
  int            max_lvl_a;
  bit            fire_a;

  logic [BI-1:0] srcb_q[$];
  logic [BO-1:0] expb_q[$];
  logic [BO-1:0] gotb_q[$];
  int            gotb_cyc[$];
  int            doneb_cyc[$];
  bit            bitsb_q[$];
  int            wreq_b;
  bit            fire_b;

  int wr_mode;   // 0: sink always ready, 1: toggle, 2: random
  int rd_rand;   // 1: source randomly withholds ready

  typedef struct {
    logic [AI-1:0] din;
    logic [AO-1:0] dout0;
    logic [AO-1:0] dout1;
  } vec_a_t;

  typedef struct {
    logic          push;
    logic [BI-1:0] din;
    logic [BO-1:0] dout;
  } vec_b_t;

  vec_a_t va[2];
  vec_b_t vb[4];

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (reset) begin
      fire_a = 1'b0;
      fire_b = 1'b0;
    end else begin
      if (ifa.m_unpacked_write_req && ifa.m_unpacked_write_ready) begin
        gota_q.push_back(ifa.m_unpacked_write_data);
        gota_cyc.push_back(cyc);
      end
      if (ifa.m_packed_read_req) reqa_cyc.push_back(cyc);
      if (int'(ifa.dbg_level) > max_lvl_a) max_lvl_a = int'(ifa.dbg_level);
      fire_a = ifa.m_packed_read_req;

      if (ifb.m_unpacked_write_req && ifb.m_unpacked_write_ready) begin
        gotb_q.push_back(ifb.m_unpacked_write_data);
        gotb_cyc.push_back(cyc);
      end
      if (ifb.m_unpacked_write_req) wreq_b++;
      if (ifb.flush_done) doneb_cyc.push_back(cyc);
      fire_b = ifb.m_packed_read_req;
    end
  end

  // ---------------- driver (source + sink) ----------------
  function automatic logic sink_ready();
    case (wr_mode)
      1:       return (cyc % 2) == 0;
      2:       return $urandom_range(0, 1) == 1;
      default: return 1'b1;
    endcase
  endfunction

  initial forever begin
    @(posedge clk);
    #1;
    if (fire_a && !reset && srca_q.size() > 0) ifa.m_packed_read_data = srca_q.pop_front();
    if (fire_b && !reset && srcb_q.size() > 0) ifb.m_packed_read_data = srcb_q.pop_front();
    ifa.m_packed_read_ready    = (srca_q.size() > 0) && (rd_rand == 0 || $urandom_range(0, 1) == 1);
    ifb.m_packed_read_ready    = (srcb_q.size() > 0) && (rd_rand == 0 || $urandom_range(0, 1) == 1);
    ifa.m_unpacked_write_ready = sink_ready();
    ifb.m_unpacked_write_ready = sink_ready();
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference model: the input stream is a flat bit sequence cut into output words.
  task automatic push_a(input logic [AI-1:0] w);
    srca_q.push_back(w);
    for (int i = 0; i < AI; i++) bitsa_q.push_back(w[i]);
    while (bitsa_q.size() >= AO) begin
      logic [AO-1:0] o;
      for (int i = 0; i < AO; i++) o[i] = bitsa_q.pop_front();
      expa_q.push_back(o);
    end
  endtask

  task automatic push_b(input logic [BI-1:0] w);
    srcb_q.push_back(w);
    for (int i = 0; i < BI; i++) bitsb_q.push_back(w[i]);
    while (bitsb_q.size() >= BO) begin
      logic [BO-1:0] o;
      for (int i = 0; i < BO; i++) o[i] = bitsb_q.pop_front();
      expb_q.push_back(o);
    end
  endtask

  task automatic model_flush_b();
    logic [BO-1:0] o;
    if (bitsb_q.size() > 0) begin
      o = '0;
      for (int i = 0; i < bitsb_q.size(); i++) o[i] = bitsb_q[i];
      expb_q.push_back(o);
      bitsb_q.delete();
    end
  endtask

  task automatic clear_a();
    srca_q.delete(); expa_q.delete(); gota_q.delete(); gota_cyc.delete();
    reqa_cyc.delete(); bitsa_q.delete(); max_lvl_a = 0;
  endtask

  task automatic clear_b();
    srcb_q.delete(); expb_q.delete(); gotb_q.delete(); gotb_cyc.delete();
    doneb_cyc.delete(); bitsb_q.delete();
  endtask

  task automatic wait_a(input int n, input int budget);
    int t = 0;
    while (gota_q.size() < n && t < budget) begin
      @(posedge clk);
      t++;
    end
    repeat (4) @(posedge clk);
    #2;
  endtask

  task automatic wait_b(input int n, input int budget);
    int t = 0;
    while (gotb_q.size() < n && t < budget) begin
      @(posedge clk);
      t++;
    end
    repeat (4) @(posedge clk);
    #2;
  endtask

  task automatic drain_src_b(input int budget);
    int t = 0;
    while (srcb_q.size() > 0 && t < budget) begin
      @(posedge clk);
      #2;
      t++;
    end
    check("b_src_drained", srcb_q.size(), 0);
  endtask

  task automatic compare_a(input string tag);
    check({tag, "_count"}, gota_q.size(), expa_q.size());
    for (int i = 0; i < gota_q.size() && i < expa_q.size(); i++)
      check($sformatf("%s_w%0d", tag, i), gota_q[i], expa_q[i]);
  endtask

  task automatic compare_b(input string tag);
    check({tag, "_count"}, gotb_q.size(), expb_q.size());
    for (int i = 0; i < gotb_q.size() && i < expb_q.size(); i++)
      check($sformatf("%s_w%0d", tag, i), gotb_q[i], expb_q[i]);
  endtask

  task automatic pulse_flush_b(output int at_cyc);
    ifb.flush = 1'b1;
    at_cyc = cyc;
    @(posedge clk);
    #2;
    ifb.flush = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int fl_cyc;
    int base;
    int n;
    int t;

    ifa.m_packed_read_ready = 1'b0; ifa.m_packed_read_data = '0;
    ifa.m_unpacked_write_ready = 1'b0; ifa.flush = 1'b0;
    ifb.m_packed_read_ready = 1'b0; ifb.m_packed_read_data = '0;
    ifb.m_unpacked_write_ready = 1'b0; ifb.flush = 1'b0;
    wr_mode = 0; rd_rand = 0; max_lvl_a = 0; wreq_b = 0;

    va[0] = '{{64'h1111_1111_1111_1111, 64'h0}, 64'h0, 64'h1111_1111_1111_1111};
    va[1] = '{{64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222},
              64'h2222_2222_2222_2222, 64'h3333_3333_3333_3333};
    vb[0] = '{1'b1, 64'hAAAA_BBBB_CCCC_DDDD, 48'hBBBB_CCCC_DDDD};
    vb[1] = '{1'b1, 64'h1111_2222_3333_4444, 48'h3333_4444_AAAA};
    vb[2] = '{1'b1, 64'h5555_6666_7777_8888, 48'h8888_1111_2222};
    vb[3] = '{1'b0, 64'h0,                   48'h5555_6666_7777};

    // reset state
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("rst_a_wreq",  ifa.m_unpacked_write_req, 0);
    check("rst_a_wdata", ifa.m_unpacked_write_data, 0);
    check("rst_a_rreq",  ifa.m_packed_read_req, 0);
    check("rst_a_level", ifa.dbg_level, 0);
    check("rst_b_wreq",  ifb.m_unpacked_write_req, 0);
    check("rst_b_done",  ifb.flush_done, 0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #2;

    // 128->64 table, sink always ready: four back-to-back words, 2-cycle latency
    clear_a();
    for (int i = 0; i < 2; i++) begin
      srca_q.push_back(va[i].din);
      expa_q.push_back(va[i].dout0);
      expa_q.push_back(va[i].dout1);
    end
    wait_a(4, 100);
    compare_a("t1");
    if (gota_cyc.size() == 4 && reqa_cyc.size() > 0) begin
      check("t1_latency", gota_cyc[0] - reqa_cyc[0], 2);
      for (int i = 1; i < 4; i++) check($sformatf("t1_consec%0d", i), gota_cyc[i] - gota_cyc[0], i);
    end

    // same stream with the sink toggling ready
    clear_a();
    wr_mode = 1;
    for (int i = 0; i < 2; i++) begin
      srca_q.push_back(va[i].din);
      expa_q.push_back(va[i].dout0);
      expa_q.push_back(va[i].dout1);
    end
    wait_a(4, 100);
    compare_a("t3");
    check("t3_level_bound", max_lvl_a <= AI + AO, 1);
    wr_mode = 0;

    // 64->48 table
    clear_b();
    for (int i = 0; i < 4; i++) begin
      if (vb[i].push) srcb_q.push_back(vb[i].din);
      expb_q.push_back(vb[i].dout);
    end
    wait_b(4, 100);
    compare_b("t2");

    // single word then flush: one full word and a zero-padded tail
    clear_b();
    srcb_q.push_back(64'h0123_4567_89AB_CDEF);
    expb_q.push_back(48'h4567_89AB_CDEF);
    expb_q.push_back(48'h0000_0000_0123);
    drain_src_b(50);
    pulse_flush_b(fl_cyc);
    wait_b(2, 50);
    compare_b("t4");
    check("t4_done_count", doneb_cyc.size(), 1);
    if (doneb_cyc.size() == 1 && gotb_cyc.size() == 2)
      check("t4_done_cycle", doneb_cyc[0], gotb_cyc[1] + 1);

    // flush on an empty buffer
    clear_b();
    base = wreq_b;
    pulse_flush_b(fl_cyc);
    repeat (5) @(posedge clk);
    #2;
    check("t5_done_count", doneb_cyc.size(), 1);
    if (doneb_cyc.size() == 1) check("t5_done_cycle", doneb_cyc[0], fl_cyc + 1);
    check("t5_no_wreq", wreq_b - base, 0);

    // asynchronous reset mid-stream while a read is in flight
    clear_a();
    wr_mode = 2; rd_rand = 1;
    for (int i = 0; i < 16; i++) push_a({$urandom, $urandom, $urandom, $urandom});
    t = 0;
    while (!(ifa.dbg_rd_valid && ifa.dbg_level != 0) && t < 200) begin
      @(posedge clk); #2;
      t++;
    end
    check("t6_armed", ifa.dbg_rd_valid && ifa.dbg_level != 0, 1);
    #1 reset = 1'b1;
    #1;
    check("t6_wreq",     ifa.m_unpacked_write_req, 0);
    check("t6_wdata",    ifa.m_unpacked_write_data, 0);
    check("t6_rreq",     ifa.m_packed_read_req, 0);
    check("t6_level",    ifa.dbg_level, 0);
    check("t6_rd_valid", ifa.dbg_rd_valid, 0);
    @(posedge clk); #2;
    clear_a(); clear_b();
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #2;

    // randomized 128->64 stream after reset: no stale bits
    n = $urandom_range(8, 20);
    for (int i = 0; i < n; i++) push_a({$urandom, $urandom, $urandom, $urandom});
    wait_a(expa_q.size(), 3000);
    compare_a("r_a");
    check("r_a_level_bound", max_lvl_a <= AI + AO, 1);

    // randomized 64->48 stream ending in a flush
    n = $urandom_range(5, 11);
    for (int i = 0; i < n; i++) push_b({$urandom, $urandom});
    drain_src_b(3000);
    pulse_flush_b(fl_cyc);
    model_flush_b();
    wait_b(expb_q.size(), 3000);
    compare_b("r_b");
    check("r_b_done_count", doneb_cyc.size(), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule
